// File: rtl/mat_seq_ctrl_pkg.sv
// rtl/mat_seq_ctrl_pkg.sv - shared states, opcodes and frame byte defaults
package mat_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_A,
        RX_B,
        COMPUTE,
        TX_REQ,
        TX_ACK,
        ERR_TX
    } state_t;

    localparam logic [7:0] OP_MUL       = 8'h01;
    localparam logic [7:0] OP_ADD       = 8'h02;
    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
    localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

endpackage

// File: rtl/mat_seq_ctrl_mac.sv
// rtl/mat_seq_ctrl_mac.sv - shared 8x8 multiplier with 16-bit accumulator
module mac_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] res
);

    logic [15:0] acc;
    logic [15:0] prod;
    logic [15:0] sum;

    // clr restarts the sum in the same cycle as the product is added
    assign prod = {8'd0, a} * {8'd0, b};
    assign sum  = (clr ? 16'd0 : acc) + prod;
    assign res  = sum[7:0];

    // accumulator register; idles at zero when not stepping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end else if (clr) begin
            acc <= '0;
        end
    end

endmodule

// File: rtl/mat_seq_ctrl.sv
// rtl/mat_seq_ctrl.sv - frame parser, MAC sequencer and result transmitter
module mat_seq_ctrl
    import mat_seq_ctrl_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 1000000,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
    parameter logic [7:0] ERR_BYTE    = ERR_BYTE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       tx_ready,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       done,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    state_t      state, state_n;
    logic [1:0]  idx;
    logic [2:0]  step;
    logic [2:0]  j;
    logic [31:0] tcnt;
    logic        is_mul;
    logic        err_mode;
    logic [7:0]  a_m [4];
    logic [7:0]  b_m [4];
    logic [7:0]  r   [4];
    logic [7:0]  chk;
    logic [7:0]  tx_sel;
    logic [7:0]  mac_res;
    logic [7:0]  add_sum;
    logic [7:0]  step_res;
    logic [1:0]  res_idx;
    logic        last_step;
    logic        legal;
    logic        timeout_hit;
    logic        mac_en;
    logic        mac_clr;

    assign busy        = (state != IDLE);
    assign legal       = (rx_byte == OP_MUL) || (rx_byte == OP_ADD);
    assign timeout_hit = (tcnt == TO_LAST);

    // multiply: step = {e, t}; A[e/2][t] and B[t][e%2] as flat row-major indices
    assign mac_en    = (state == COMPUTE) && is_mul;
    assign mac_clr   = ~step[0];
    assign add_sum   = a_m[step[1:0]] + b_m[step[1:0]];
    assign step_res  = is_mul ? mac_res : add_sum;
    assign res_idx   = is_mul ? step[2:1] : step[1:0];
    assign last_step = is_mul ? (step == 3'd7) : (step == 3'd3);

    mac_unit u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (a_m[{step[2], step[0]}]),
        .b   (b_m[{step[0], step[1]}]),
        .res (mac_res)
    );

    // result frame byte for the current tx index
    always_comb begin
        tx_sel = chk;
        case (j)
            3'd0:    tx_sel = HDR_BYTE;
            3'd1:    tx_sel = r[0];
            3'd2:    tx_sel = r[1];
            3'd3:    tx_sel = r[2];
            3'd4:    tx_sel = r[3];
            default: tx_sel = chk;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next-state logic; the error byte reuses TX_ACK and err_mode routes it home
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (rx_valid) state_n = legal ? RX_A : ERR_TX;
            RX_A:    if (rx_valid && idx == 2'd3) state_n = RX_B;
                     else if (!rx_valid && timeout_hit) state_n = IDLE;
            RX_B:    if (rx_valid && idx == 2'd3) state_n = COMPUTE;
                     else if (!rx_valid && timeout_hit) state_n = IDLE;
            COMPUTE: if (last_step) state_n = TX_REQ;
            TX_REQ:  if (tx_ready) state_n = TX_ACK;
            TX_ACK:  if (!tx_ready) state_n = (err_mode || j == 3'd5) ? IDLE : TX_REQ;
            ERR_TX:  if (tx_ready) state_n = TX_ACK;
            default: state_n = IDLE;
        endcase
    end

    // operand capture, compute sequencing, tx handshake and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            step      <= '0;
            j         <= '0;
            tcnt      <= '0;
            is_mul    <= 1'b0;
            err_mode  <= 1'b0;
            chk       <= '0;
            tx_start  <= 1'b0;
            tx_byte   <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_m[i] <= '0;
                b_m[i] <= '0;
                r[i]   <= '0;
            end
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;
            if (rx_valid && (state inside {COMPUTE, TX_REQ, TX_ACK, ERR_TX})) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (legal) begin
                            is_mul   <= (rx_byte == OP_MUL);
                            overrun  <= 1'b0;
                            err_mode <= 1'b0;
                            idx      <= '0;
                            step     <= '0;
                            tcnt     <= '0;
                        end else begin
                            frame_err <= 1'b1;
                            tx_byte   <= ERR_BYTE;
                            err_mode  <= 1'b1;
                        end
                    end
                end
                RX_A, RX_B: begin
                    if (rx_valid) begin
                        if (state == RX_A) a_m[idx] <= rx_byte;
                        else               b_m[idx] <= rx_byte;
                        idx  <= idx + 2'd1;
                        tcnt <= '0;
                    end else if (timeout_hit) begin
                        frame_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                COMPUTE: begin
                    step <= step + 3'd1;
                    if (!is_mul || step[0]) r[res_idx] <= step_res;
                    if (last_step) begin
                        chk <= r[0] ^ r[1] ^ r[2] ^ step_res;
                        j   <= '0;
                    end
                end
                TX_REQ: begin
                    if (tx_ready) begin
                        tx_start <= 1'b1;
                        tx_byte  <= tx_sel;
                    end
                end
                ERR_TX: begin
                    if (tx_ready) tx_start <= 1'b1;
                end
                TX_ACK: begin
                    if (!tx_ready) begin
                        tx_start <= 1'b0;
                        if (!err_mode) begin
                            if (j == 3'd5) done <= 1'b1;
                            else           j    <= j + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_seq_ctrl.sv
// tb/tb_mat_seq_ctrl.sv - self-checking bench for mat_seq_ctrl
module tb_mat_seq_ctrl;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [47:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       busy;
    logic       done;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int ntx = 0;
    int lag_lo = 3;
    int lag_hi = 5;
    bit model_busy = 0;
    logic [7:0] exp_q [$];
    vec_t vecs [5];

    mat_seq_ctrl #(.TIMEOUT_CYC(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_ready  (tx_ready),
        .tx_start  (tx_start),
        .tx_byte   (tx_byte),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // pulse counters
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (frame_err) ferr_cnt++;
    end

    // transmitter model: accept on tx_start, drop ready after lag_lo, raise after lag_hi
    initial begin
        logic [7:0] got;
        logic [7:0] e;
        bit stable;
        tx_ready = 1;
        forever begin
            @(negedge clk);
            if (rst && tx_start && tx_ready) begin
                model_busy = 1;
                got = tx_byte;
                ntx++;
                if (exp_q.size() == 0) begin
                    chk("tx_unexpected", 64'(got), 64'h100);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", 64'(got), 64'(e));
                end
                stable = 1;
                for (int i = 0; i < lag_lo; i++) begin
                    @(negedge clk);
                    if (tx_start && tx_byte !== got) stable = 0;
                end
                tx_ready = 0;
                for (int i = 0; i < lag_hi; i++) begin
                    @(negedge clk);
                    if (tx_start && tx_byte !== got) stable = 0;
                end
                tx_ready = 1;
                model_busy = 0;
                chk("tx_stable", 64'(stable), 64'd1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_valid = 1;
        @(negedge clk);
        rx_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || model_busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_bound", 64'(n < 20000), 64'd1);
    endtask

    task automatic send_frame(input vec_t v);
        for (int i = 0; i < 6; i++) exp_q.push_back(v.exp[47-8*i -: 8]);
        send_byte(v.op);
        chk("overrun_clr", 64'(overrun), 64'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (2) @(negedge clk);
            if (i < 4) send_byte(v.a[31-8*i -: 8]);
            else       send_byte(v.b[31-8*(i-4) -: 8]);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit inject);
        int d0 = done_cnt;
        int f0 = ferr_cnt;
        int t0 = ntx;
        int lat = 0;
        send_frame(v);
        while (!tx_start && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), (v.op == 8'h01) ? 64'd9 : 64'd5);
        if (inject) begin
            repeat (20) @(negedge clk);
            send_byte(8'h55);
        end
        wait_idle();
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("no_frame_err", 64'(ferr_cnt - f0), 64'd0);
        chk("tx_count", 64'(ntx - t0), 64'd6);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        if (inject) chk("overrun_set", 64'(overrun), 64'd1);
    endtask

    initial begin
        int d0, f0, t0, n;
        vecs[0] = '{op: 8'h01, a: 32'h01020304, b: 32'h05060708, exp: 48'hA5_13_16_2B_32_1C};
        vecs[1] = '{op: 8'h02, a: 32'h01020304, b: 32'h05060708, exp: 48'hA5_06_08_0A_0C_08};
        vecs[2] = '{op: 8'h01, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, exp: 48'hA5_02_02_02_02_00};
        vecs[3] = '{op: 8'h02, a: 32'h80801020, b: 32'h8001F0E0, exp: 48'hA5_00_81_00_00_81};
        vecs[4] = '{op: 8'h01, a: 32'h01000001, b: 32'h09080706, exp: 48'hA5_09_08_07_06_00};

        rst = 0;
        rx_valid = 0;
        rx_byte = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({tx_start, busy, done, frame_err, overrun, tx_byte}), 64'd0);
        rst = 1;
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            run_vec(vecs[k], 0);
            repeat (3) @(negedge clk);
        end

        // illegal opcode
        d0 = done_cnt; f0 = ferr_cnt; t0 = ntx;
        exp_q.push_back(8'hEE);
        send_byte(8'h07);
        chk("err_frame_err", 64'(frame_err), 64'd1);
        chk("err_busy", 64'(busy), 64'd1);
        wait_idle();
        chk("err_tx_count", 64'(ntx - t0), 64'd1);
        chk("err_no_done", 64'(done_cnt - d0), 64'd0);
        chk("err_pulses", 64'(ferr_cnt - f0), 64'd1);
        chk("err_busy_low", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);

        // inter-byte timeout
        t0 = ntx;
        send_byte(8'h01);
        for (int i = 0; i < 3; i++) begin
            repeat (2) @(negedge clk);
            send_byte(8'h10);
        end
        n = 0;
        while (!frame_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycle", 64'(n), 64'd100);
        chk("timeout_idle", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        chk("timeout_no_tx", 64'(ntx - t0), 64'd0);

        // slow transmitter with a byte injected mid-transmit
        lag_lo = 40;
        lag_hi = 400;
        run_vec(vecs[0], 1);
        repeat (5) @(negedge clk);
        chk("overrun_sticky", 64'(overrun), 64'd1);
        lag_lo = 3;
        lag_hi = 5;
        run_vec(vecs[1], 0);
        repeat (3) @(negedge clk);

        // reset during TX_ACK
        lag_lo = 40;
        lag_hi = 400;
        send_frame(vecs[2]);
        n = 0;
        while (!(tx_start && !tx_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_tx_ack", 64'(n < 3000), 64'd1);
        #2 rst = 0;
        #1;
        chk("rst_tx_start", 64'(tx_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        n = 0;
        while (model_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("model_release", 64'(n < 1000), 64'd1);
        @(negedge clk);
        rst = 1;
        lag_lo = 3;
        lag_hi = 5;
        @(negedge clk);
        run_vec(vecs[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mat_seq_ctrl.md
Name: mat_seq_ctrl

Overview:
Frame-level controller between the UART byte interfaces and a single time-shared 8x8 multiply-accumulate unit. It parses an opcode frame, loads two 2x2 operand matrices and sequences the MAC to multiply or add them. It then schedules the result bytes, with a header and checksum, onto the UART transmitter through a level handshake. Inter-byte timeout and opcode errors return it to idle deterministically.

Parameters:
TIMEOUT_CYC, 1000000, clk cycles without rx_valid, while mid-frame, before the frame is aborted
HDR_BYTE, 8'hA5, first byte of every result frame
ERR_BYTE, 8'hEE, single-byte response to an illegal opcode

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
rx_valid  in  1  one-cycle strobe: rx_byte holds a new received byte
rx_byte  in  8  received byte
tx_ready  in  1  transmitter idle (level, may lag by many clk cycles)
tx_start  out  1  transmit request, held until tx_ready observed low
tx_byte  out  8  byte to transmit, stable while tx_start is high
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last result byte is accepted
frame_err  out  1  one-cycle pulse on timeout abort or illegal opcode
overrun  out  1  sticky; set by rx_valid in COMPUTE/TX states; cleared on next legal opcode

Behaviour:
- Reset (rst low, async): state=IDLE; all outputs 0; tx_byte=0; operand/result regs, counters and checksum=0.
- Frame in: opcode, then A00 A01 A10 A11, then B00 B01 B10 B11. Opcode 8'h01=multiply, 8'h02=add.
- IDLE: on rx_valid with a legal opcode: latch op, clear overrun, go to RX_A with idx=0. On any other byte: pulse frame_err, load tx_byte=ERR_BYTE, go to ERR_TX.
- RX_A / RX_B: each rx_valid stores rx_byte at [idx/2][idx%2] and increments idx. At idx==3: idx wraps to 0, RX_A->RX_B, RX_B->COMPUTE.
- Timeout counter: cleared on entry to RX_A and on every rx_valid. When it reaches TIMEOUT_CYC-1 in RX_A/RX_B: pulse frame_err, go to IDLE, send nothing.
- COMPUTE, multiply: 8 MAC steps, one per cycle, k=0..7, element e=k/2, term t=k%2.
  - acc = (t==0 ? 0 : acc) + A[e/2][t]*B[t][e%2].
  - At t==1, R[e] = acc[7:0]. Result is modulo 256, matching the existing datapath.
- COMPUTE, add: 4 cycles; R[e] = (A[e]+B[e])[7:0].
- Leaving COMPUTE: checksum = R0^R1^R2^R3; go to TX_REQ with tx index j=0.
- TX sequence: j=0 HDR_BYTE, j=1..4 R[j-1], j=5 checksum.
- TX_REQ: wait for tx_ready=1, then drive tx_byte and assert tx_start; go to TX_ACK.
- TX_ACK: keep tx_start high until tx_ready=0, then drop it.
  - If j<5: j++ and go to TX_REQ.
  - Else: pulse done and go to IDLE.
- ERR_TX: same REQ/ACK handshake for one ERR_BYTE, then IDLE. No done pulse.
- rx_valid during COMPUTE/TX_REQ/TX_ACK/ERR_TX: byte dropped, overrun set. rx_valid in the same cycle as the final ack is also dropped.
- Latency: last B byte strobe -> first tx_start is 9 clk for multiply, 5 clk for add, provided tx_ready is already high.
- Reset mid-frame or mid-transmit aborts immediately; tx_start drops asynchronously.

Decomposition:
- Shared package holds:
  - state enum: IDLE, RX_A, RX_B, COMPUTE, TX_REQ, TX_ACK, ERR_TX
  - opcode constants OP_MUL=8'h01, OP_ADD=8'h02
  - default HDR_BYTE and ERR_BYTE
- One sub-module, mac_unit: 8x8 multiplier plus 16-bit accumulator with clr/en inputs. It is purely the shared datapath; the controller owns all sequencing.

Test Plan:
- Multiply: 01, A=01 02 03 04, B=05 06 07 08 -> tx A5 13 16 2B 32 1C; one done pulse; frame_err never asserted.
- Add: 02, A=01 02 03 04, B=05 06 07 08 -> tx A5 06 08 0A 0C 08.
- Wrap: 01, A all FF, B all FF -> tx A5 02 02 02 02 00.
- Illegal opcode 07 -> frame_err pulse, tx EE only, busy then low.
- Timeout (TIMEOUT_CYC=100): 01 then 3 bytes, then silence -> frame_err at the 100th idle cycle, state IDLE, no tx_start.
- Slow transmitter: tx_ready drops 40 clk after tx_start and rises 400 clk later, with a byte injected during TX -> all 6 bytes sent once each, tx_byte stable throughout, overrun=1 until next opcode.
- Reset asserted mid-TX_ACK -> tx_start=0 immediately; a new frame after release completes correctly.
